exp_taylor_seq: RTL

Sequential, parametrised Taylor-series evaluator for e^x in unsigned fixed point. It accepts one operand over a valid/ready handshake and accumulates 1 + x + x²/2! + … + x^N/N! at one term per clock, using the recurrence term_i = (term_{i-1}·x)/i, so it needs one multiplier and one small-integer divider instead of a factorial table. It exits early when a term underflows to zero, and returns the result over a second valid/ready handshake. It replaces combinational exponential evaluation in the fixed-point math datapath wherever area matters more than latency.

---
 rtl/exp_taylor_seq_if.sv | 24 ++
 rtl/exp_taylor_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/exp_taylor_seq_if.sv
// Operand/result channel for exp_taylor_seq: an operand stream in, a result stream out.
// Both streams use valid/ready: a beat transfers on a rising clk edge where valid && ready
// are both 1; a source holds valid and its payload stable until that edge.
interface exp_taylor_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             ovf;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/exp_taylor_seq.sv
// Sequential Taylor-series e^x in unsigned fixed point, one term per clock via term_i = term_{i-1}*x/i.
// Define EXP_TAYLOR_SAT_EN to saturate to all-ones and flag ovf on overflow instead of wrapping.
module exp_taylor_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int TERMS = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  exp_taylor_seq_if.slave    bus,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] r_y;
  logic [7:0]       r_i;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [2*WIDTH-1:0] w_p;
  logic [2*WIDTH-1:0] w_t;
  logic [2*WIDTH-1:0] w_div;
  logic [2*WIDTH-1:0] w_q;
  logic [WIDTH-1:0]   w_term_n;
  logic [WIDTH-1:0]   w_sum_n;
  logic               w_ovf;
  logic               w_last;

  assign w_p      = {{WIDTH{1'b0}}, r_term} * {{WIDTH{1'b0}}, r_x};
  assign w_t      = w_p >> FRAC;
  assign w_div    = {{(2*WIDTH-8){1'b0}}, r_i};
  assign w_q      = w_t / w_div;
  assign w_term_n = w_q[WIDTH-1:0];

`ifdef EXP_TAYLOR_SAT_EN
  logic [WIDTH:0] w_sum_full;
  assign w_sum_full = {1'b0, r_sum} + {1'b0, w_term_n};
  // Any bit that would be lost to truncation counts as overflow.
  assign w_ovf   = (|w_t[2*WIDTH-1:WIDTH]) | (|w_q[2*WIDTH-1:WIDTH]) | w_sum_full[WIDTH];
  assign w_sum_n = w_ovf ? '1 : w_sum_full[WIDTH-1:0];
`else
  logic w_unused_q;
  assign w_unused_q = |w_q[2*WIDTH-1:WIDTH];
  assign w_ovf      = 1'b0;
  assign w_sum_n    = r_sum + w_term_n;
`endif

  assign w_last = (r_i == 8'(TERMS)) || (w_term_n == '0) || w_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_sum       <= '0;
      r_term      <= '0;
      r_y         <= '0;
      r_i         <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x        <= bus.x;
            r_sum      <= ONE;
            r_term     <= ONE;
            r_i        <= 8'd1;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum  <= w_sum_n;
          r_term <= w_term_n;
          r_i    <= r_i + 8'd1;
          if (w_last) begin
            r_y         <= w_sum_n;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Return to IDLE first; a new operand is taken on the following edge.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.ovf       = r_ovf;
  assign o_state       = r_state;

endmodule
